// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - serial shift controller (SLL/SRL/SRA/V forms/LUI), one bit per cycle.
// Define SHIFT_CTRL_FAST_EN to replace the serial loop with a single-cycle barrel shift.
module shift_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] operand,
    input  logic [4:0]        shamt_reg,
    input  logic [4:0]        shamt_imm,
    output logic [1:0]        shamt_src,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
    typedef enum logic [1:0] {K_LEFT = 2'b00, K_SRL = 2'b01, K_SRA = 2'b10} kind_t;

    state_t            state, state_n;
    kind_t             kind, kind_n, op_kind;
    logic [4:0]        cnt, cnt_n, amt;
    logic [DATA_W-1:0] result_n;
    logic [1:0]        src_n, op_src;
    logic              ill, ill_n;

    function automatic logic [DATA_W-1:0] step(input kind_t k, input logic [DATA_W-1:0] v);
        case (k)
            K_SRL:   step = {1'b0, v[DATA_W-1:1]};
            K_SRA:   step = {v[DATA_W-1], v[DATA_W-1:1]};
            default: step = {v[DATA_W-2:0], 1'b0};
        endcase
    endfunction

`ifdef SHIFT_CTRL_FAST_EN
    function automatic logic [DATA_W-1:0] barrel(input kind_t k, input logic [DATA_W-1:0] v,
                                                 input logic [4:0] a);
        case (k)
            K_SRL:   barrel = v >> a;
            K_SRA:   barrel = $unsigned($signed(v) >>> a);
            default: barrel = v << a;
        endcase
    endfunction
`endif

    always_comb begin
        amt     = shamt_imm;
        op_kind = K_LEFT;
        op_src  = 2'b10;
        case (op)
            3'b001:  op_kind = K_SRL;
            3'b010:  op_kind = K_SRA;
            3'b011:  begin amt = shamt_reg; op_src = 2'b00; end
            3'b100:  begin amt = shamt_reg; op_src = 2'b00; op_kind = K_SRL; end
            3'b101:  begin amt = shamt_reg; op_src = 2'b00; op_kind = K_SRA; end
            3'b110:  begin amt = 5'd16;     op_src = 2'b01; end
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        result_n = result;
        src_n    = shamt_src;
        kind_n   = kind;
        ill_n    = ill;
        case (state)
            IDLE: begin
                if (start) begin
                    src_n  = op_src;
                    kind_n = op_kind;
                    ill_n  = (op == 3'b111);
                    if (op == 3'b111) begin
                        // illegal op leaves result untouched
                        cnt_n   = 5'd0;
                        state_n = DONE;
                    end else begin
`ifdef SHIFT_CTRL_FAST_EN
                        result_n = barrel(op_kind, operand, amt);
                        cnt_n    = 5'd0;
                        state_n  = DONE;
`else
                        result_n = operand;
                        cnt_n    = amt;
                        state_n  = (amt == 5'd0) ? DONE : SHIFT;
`endif
                    end
                end
            end
            SHIFT: begin
                result_n = step(kind, result);
                cnt_n    = cnt - 5'd1;
                if (cnt == 5'd1) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            result    <= '0;
            shamt_src <= 2'b00;
            kind      <= K_LEFT;
            ill       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            result    <= result_n;
            shamt_src <= src_n;
            kind      <= kind_n;
            ill       <= ill_n;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign err  = done & ill;

endmodule

// File: tb/tb_shift_ctrl.sv
// tb/tb_shift_ctrl.sv - directed-vector self-checking bench for shift_ctrl.
module tb_shift_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt_reg, shamt_imm;
    logic [1:0]  shamt_src;
    logic        busy, done, err;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    bit seen;

    shift_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .operand(operand),
        .shamt_reg(shamt_reg), .shamt_imm(shamt_imm), .shamt_src(shamt_src),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int lat(input int n);
`ifdef SHIFT_CTRL_FAST_EN
        lat = 1;
`else
        lat = n + 1;
`endif
    endfunction

    // Start in cycle 0, then count cycles until done (bounded).
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] val,
                       input logic [4:0] sr, input logic [4:0] si, input int exp_cyc,
                       input logic [31:0] exp_res, input logic [1:0] exp_src, input bit chk_src,
                       input bit exp_err);
        @(negedge clk);
        op = o; operand = val; shamt_reg = sr; shamt_imm = si; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_cycle"}, cyc, exp_cyc);
        check({tag, "_result"}, result, exp_res);
        if (chk_src) check({tag, "_src"}, {30'd0, shamt_src}, {30'd0, exp_src});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; operand = '0; shamt_reg = '0; shamt_imm = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'd0, busy, done, err, 1'b0}, 32'd0);
        check("rst_src", {30'd0, shamt_src}, 32'd0);
        reset = 1'b0;

        run("sll",  3'b000, 32'h0000_0001, 5'd0,  5'd4, lat(4),  32'h0000_0010, 2'b10, 1, 0);
        run("srav", 3'b101, 32'h8000_0000, 5'd31, 5'd0, lat(31), 32'hFFFF_FFFF, 2'b00, 1, 0);
        run("lui",  3'b110, 32'h0000_1234, 5'd3,  5'd7, lat(16), 32'h1234_0000, 2'b01, 1, 0);
        run("srl0", 3'b001, 32'hA5A5_A5A5, 5'd9,  5'd0, 1,       32'hA5A5_A5A5, 2'b10, 1, 0);
        run("ill",  3'b111, 32'hDEAD_BEEF, 5'd5,  5'd5, 1,       32'hA5A5_A5A5, 2'b00, 0, 1);
        run("srl",  3'b001, 32'hF000_0000, 5'd0,  5'd4, lat(4),  32'h0F00_0000, 2'b10, 1, 0);
        run("sra",  3'b010, 32'hF000_0000, 5'd0,  5'd4, lat(4),  32'hFF00_0000, 2'b10, 1, 0);
        run("sllv", 3'b011, 32'h1234_5678, 5'd8,  5'd0, lat(8),  32'h3456_7800, 2'b00, 1, 0);
        run("srlv", 3'b100, 32'h8000_0000, 5'd31, 5'd0, lat(31), 32'h0000_0001, 2'b00, 1, 0);

        // start during the DONE cycle is ignored
        op = 3'b000; operand = 32'h0000_0003; shamt_imm = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", {31'd0, busy}, 32'd0);
        check("done_start_result", result, 32'h0000_0001);

        // second start while busy is neither taken nor queued
        @(negedge clk);
        op = 3'b001; operand = 32'h0000_0400; shamt_imm = 5'd10; start = 1'b1;
        @(negedge clk);
        op = 3'b000; operand = 32'h0000_0001; shamt_imm = 5'd1;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_cycle", cyc, lat(10));
        check("busy_result", result, 32'h0000_0001);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("busy_no_queue", {31'd0, seen}, 32'd0);

        // asynchronous reset in cycle 3 of a 10-bit shift
        op = 3'b000; operand = 32'h0000_0001; shamt_imm = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_flags", {29'd0, busy, done, err}, 32'd0);
        check("mid_rst_src", {30'd0, shamt_src}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("mid_rst_no_done", {31'd0, seen}, 32'd0);

        run("post_rst", 3'b010, 32'h8000_0010, 5'd0, 5'd4, lat(4), 32'hF800_0001, 2'b10, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
